// File: rtl/aes_pkg.sv
// Shared AES constants, GF(2^8) helper and the FSM encoding for the iterative
// MixColumns stage.
package aes_pkg;

  localparam int         AES_STATE_W = 128;
  localparam int         AES_COL_W   = 32;
  localparam logic [7:0] AES_POLY    = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_t;

  // Multiply by x in GF(2^8), reducing modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mix_column_word.sv
// Combinational MixColumns of one 32-bit column (row 0 in the top byte).
module mix_column_word
  import aes_pkg::*;
(
  input  logic [AES_COL_W-1:0] col_in,
  output logic [AES_COL_W-1:0] col_out
);

  logic [7:0] s_byte [4];
  logic [7:0] x_byte [4];

  genvar gi;

  for (gi = 0; gi < 4; gi++) begin : g_row
    assign s_byte[gi] = col_in[31-8*gi -: 8];
    assign x_byte[gi] = xtime(s_byte[gi]);
  end

  // Row r: 2*s[r] ^ 3*s[r+1] ^ s[r+2] ^ s[r+3], indices taken mod 4.
  for (gi = 0; gi < 4; gi++) begin : g_mix
    assign col_out[31-8*gi -: 8] = x_byte[gi]
                                 ^ x_byte[(gi+1)%4] ^ s_byte[(gi+1)%4]
                                 ^ s_byte[(gi+2)%4]
                                 ^ s_byte[(gi+3)%4];
  end

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns: one column per clock through a single shared mixer,
// valid/ready on both sides, with a per-block bypass for the final round.
module mix_columns_iter
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] state_in,
  input  logic                   bypass,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] state_out,
  output logic                   busy
);

  fsm_t                   fsm_reg;
  logic [1:0]             col_reg;
  logic [AES_STATE_W-1:0] state_reg;

  logic [AES_COL_W-1:0]   col_word [4];
  logic [AES_COL_W-1:0]   col_sel;
  logic [AES_COL_W-1:0]   col_mixed;
  logic [AES_STATE_W-1:0] state_mixed;

  genvar gi;

  // Split the working register into columns and rebuild it with only the
  // selected column replaced by the mixer output.
  for (gi = 0; gi < 4; gi++) begin : g_col
    assign col_word[gi] = state_reg[AES_STATE_W-1-32*gi -: 32];
    assign state_mixed[AES_STATE_W-1-32*gi -: 32] =
        (col_reg == 2'(gi)) ? col_mixed : col_word[gi];
  end

  assign col_sel = col_word[col_reg];

  mix_column_word u_mix (
    .col_in  (col_sel),
    .col_out (col_mixed)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_reg   <= IDLE;
      col_reg   <= 2'd0;
      state_reg <= '0;
    end else begin
      case (fsm_reg)
        IDLE: begin
          if (in_valid) begin
            state_reg <= state_in;
            col_reg   <= 2'd0;
            fsm_reg   <= bypass ? DONE : BUSY;
          end
        end
        BUSY: begin
          state_reg <= state_mixed;
          col_reg   <= col_reg + 2'd1;
          if (col_reg == 2'd3) begin
            fsm_reg <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm_reg <= IDLE;
          end
        end
        default: fsm_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (fsm_reg == IDLE);
  assign out_valid = (fsm_reg == DONE);
  assign busy      = (fsm_reg == BUSY);
  assign state_out = state_reg;

endmodule
